// File: rtl/game_seq.sv
// game_seq: game sequencer for the VGA paddle/ball game.
// Owns the game state machine, the lives and level counters, the debounced
// start/pause button, the level-dependent position-update strobe and the
// HUD blink.
//
// Ports
//   clk_50m         in   system clock, 50 MHz
//   rst_n           in   asynchronous active-low reset
//   start_btn       in   raw start/pause push-button (asynchronous, active-high)
//   ball_lost       in   1-cycle pulse: ball reached the floor
//   all_points_hit  in   1-cycle pulse: all score points cleared
//   state     [2:0] out  IDLE=0 SERVE=1 PLAY=2 PAUSE=3 LOST=4 OVER=5
//   move_en         out  1-cycle position-update strobe, PLAY only
//   round_rst       out  1-cycle pulse: recentre ball and board
//   new_game        out  1-cycle pulse: clear score, respawn points
//   lives     [1:0] out  remaining lives
//   level     [3:0] out  current level 0..15
//   blink           out  HUD blink square wave in PAUSE/OVER, else 0
module game_seq #(
  parameter int TICK_BASE    = 500000,
  parameter int TICK_STEP    = 50000,
  parameter int TICK_MIN     = 200000,
  parameter int SERVE_TICKS  = 100,
  parameter int LIVES_INIT   = 3,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int BLINK_CYC    = 25000000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       ball_lost,
  input  logic       all_points_hit,
  output logic [2:0] state,
  output logic       move_en,
  output logic       round_rst,
  output logic       new_game,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic       blink
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int TM_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int BL_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    LOST  = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t cur, nxt;

  logic            sync_a, sync_b, db_level, press;
  logic [DB_W-1:0] db_cnt;
  logic [19:0]     cnt, period;
  logic signed [20:0] period_raw;
  logic            tick, expire;
  logic [TM_W-1:0] timer;
  logic [BL_W-1:0] blink_cnt;
  logic            blink_zone;
  logic [1:0]      lives_n;
  logic [3:0]      level_n;
  logic            round_rst_n, new_game_n;

  assign state = cur;

  // Debounce: the counter only runs while the synced level differs from the
  // debounced level, so any bounce back to the old level restarts it.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync_a <= start_btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        db_cnt   <= '0;
        db_level <= sync_b;
        press    <= sync_b;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Signed arithmetic so a large level underflows below the floor and clamps.
  assign period_raw = 21'(TICK_BASE) - 21'(level) * 21'(TICK_STEP);
  assign period     = (period_raw < $signed(21'(TICK_MIN))) ? 20'(TICK_MIN) : period_raw[19:0];

  // >= rather than == so a period that shrinks mid-count still fires at once.
  assign tick   = (cur != PAUSE) && (cnt >= period - 20'd1);
  assign expire = tick && (timer == TM_W'(SERVE_TICKS - 1));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cur != PAUSE) begin
      cnt <= tick ? 20'd0 : cnt + 20'd1;
    end
  end

  always_comb begin
    nxt         = cur;
    lives_n     = lives;
    level_n     = level;
    round_rst_n = 1'b0;
    new_game_n  = 1'b0;
    case (cur)
      IDLE: begin
        if (press) begin
          nxt         = SERVE;
          lives_n     = 2'(LIVES_INIT);
          level_n     = 4'd0;
          round_rst_n = 1'b1;
          new_game_n  = 1'b1;
        end
      end
      SERVE: begin
        if (expire) nxt = PLAY;
      end
      PLAY: begin
        if (ball_lost) begin
          nxt = LOST;
          if (lives != 2'd0) lives_n = lives - 2'd1;
        end else if (press) begin
          nxt = PAUSE;
        end else if (all_points_hit && level != 4'd15) begin
          level_n = level + 4'd1;
        end
      end
      PAUSE: begin
        if (press) nxt = PLAY;
      end
      LOST: begin
        if (expire) begin
          if (lives == 2'd0) begin
            nxt = OVER;
          end else begin
            nxt         = SERVE;
            round_rst_n = 1'b1;
          end
        end
      end
      OVER: begin
        if (press) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= IDLE;
      lives     <= 2'(LIVES_INIT);
      level     <= 4'd0;
      round_rst <= 1'b0;
      new_game  <= 1'b0;
      move_en   <= 1'b0;
    end else begin
      cur       <= nxt;
      lives     <= lives_n;
      level     <= level_n;
      round_rst <= round_rst_n;
      new_game  <= new_game_n;
      move_en   <= tick && (cur == PLAY);
    end
  end

  // Tick timer restarts on every state entry so SERVE and LOST each get a
  // full SERVE_TICKS.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (nxt != cur) begin
      timer <= '0;
    end else if (tick && (cur == SERVE || cur == LOST)) begin
      timer <= timer + 1'b1;
    end
  end

  assign blink_zone = (nxt == PAUSE) || (nxt == OVER);

  // Blink phase restarts on entering PAUSE/OVER so the HUD always begins dark.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!blink_zone || nxt != cur) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BL_W'(BLINK_CYC - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_game_seq.sv
// tb_game_seq: self-checking bench for game_seq with small timing parameters.
// A behavioural game model runs alongside the DUT and every output is
// compared against it each cycle; literal checks pin key scenario results.
module tb_game_seq;

  localparam int BASE  = 10;
  localparam int STEP  = 2;
  localparam int MIN   = 4;
  localparam int SERVE = 3;
  localparam int LIVES = 3;
  localparam int DEB   = 4;
  localparam int BLINK = 3;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_LOST  = 4;
  localparam int S_OVER  = 5;

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_btn = 1'b0;
  logic       ball_lost = 1'b0;
  logic       all_points_hit = 1'b0;
  logic [2:0] state;
  logic       move_en, round_rst, new_game, blink;
  logic [1:0] lives;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int ng_count = 0, rr_count = 0, me_count = 0, blink_hi = 0;

  // Model state
  int m_state, m_lives, m_level, m_cnt, m_ticks, m_age, m_run;
  bit m_move, m_rr, m_ng, m_blink, m_press, m_deb, m_s1, m_s2;

  game_seq #(
    .TICK_BASE(BASE), .TICK_STEP(STEP), .TICK_MIN(MIN), .SERVE_TICKS(SERVE),
    .LIVES_INIT(LIVES), .DEBOUNCE_CYC(DEB), .BLINK_CYC(BLINK)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .start_btn(start_btn),
    .ball_lost(ball_lost), .all_points_hit(all_points_hit),
    .state(state), .move_en(move_en), .round_rst(round_rst),
    .new_game(new_game), .lives(lives), .level(level), .blink(blink)
  );

  always #5 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: period from level, strobe every period cycles (frozen in
  // pause), SERVE/LOST last SERVE ticks, button press after DEB stable
  // cycles behind a two-stage synchronizer.
  always @(posedge clk_50m or negedge rst_n) begin : model
    int period, ns, nl, nlev, nticks, nage, ncnt, run;
    bit tick, expire, synced, deb, npress, nblink;
    if (!rst_n) begin
      m_state <= S_IDLE; m_lives <= LIVES; m_level <= 0; m_cnt <= 0;
      m_ticks <= 0; m_age <= 0; m_run <= 0;
      m_move <= 0; m_rr <= 0; m_ng <= 0; m_blink <= 0; m_press <= 0;
      m_deb <= 0; m_s1 <= 0; m_s2 <= 0;
    end else begin
      period = BASE - m_level * STEP;
      if (period < MIN) period = MIN;
      tick   = (m_state != S_PAUSE) && (m_cnt >= period - 1);
      ncnt   = (m_state == S_PAUSE) ? m_cnt : (tick ? 0 : m_cnt + 1);
      expire = tick && (m_ticks + 1 == SERVE);
      ns = m_state; nl = m_lives; nlev = m_level;
      m_rr <= 0; m_ng <= 0;
      case (m_state)
        S_IDLE:  if (m_press) begin ns = S_SERVE; nl = LIVES; nlev = 0; m_ng <= 1; m_rr <= 1; end
        S_SERVE: if (expire) ns = S_PLAY;
        S_PLAY: begin
          if (ball_lost) begin ns = S_LOST; nl = (m_lives > 0) ? m_lives - 1 : 0; end
          else if (m_press) ns = S_PAUSE;
          else if (all_points_hit) nlev = (m_level < 15) ? m_level + 1 : 15;
        end
        S_PAUSE: if (m_press) ns = S_PLAY;
        S_LOST: begin
          if (expire) begin
            if (m_lives == 0) ns = S_OVER;
            else begin ns = S_SERVE; m_rr <= 1; end
          end
        end
        S_OVER:  if (m_press) ns = S_IDLE;
        default: ns = S_IDLE;
      endcase
      if (ns != m_state) nticks = 0;
      else if (tick && (m_state == S_SERVE || m_state == S_LOST)) nticks = m_ticks + 1;
      else nticks = m_ticks;
      if (ns == S_PAUSE || ns == S_OVER) begin
        nage   = (ns != m_state) ? 0 : m_age + 1;
        nblink = ((nage / BLINK) % 2) == 1;
      end else begin
        nage = 0; nblink = 0;
      end
      synced = m_s2; run = m_run; deb = m_deb; npress = 0;
      if (synced == deb) run = 0;
      else begin
        run++;
        if (run == DEB) begin deb = synced; run = 0; npress = synced; end
      end
      m_move <= tick && (m_state == S_PLAY);
      m_state <= ns; m_lives <= nl; m_level <= nlev; m_cnt <= ncnt;
      m_ticks <= nticks; m_age <= nage; m_blink <= nblink;
      m_s1 <= start_btn; m_s2 <= m_s1; m_deb <= deb; m_run <= run; m_press <= npress;
    end
  end

  // Per-cycle comparison against the model plus event counters.
  always @(negedge clk_50m) begin
    if (chk_en) begin
      checkOutput("state", int'(state), m_state);
      checkOutput("lives", int'(lives), m_lives);
      checkOutput("level", int'(level), m_level);
      checkOutput("move_en", int'(move_en), int'(m_move));
      checkOutput("round_rst", int'(round_rst), int'(m_rr));
      checkOutput("new_game", int'(new_game), int'(m_ng));
      checkOutput("blink", int'(blink), int'(m_blink));
      if (new_game)  ng_count <= ng_count + 1;
      if (round_rst) rr_count <= rr_count + 1;
      if (move_en)   me_count <= me_count + 1;
      if (blink)     blink_hi <= blink_hi + 1;
    end
  end

  task automatic applyStimulus(input bit btn, input bit lost, input bit aph, input int n);
    start_btn = btn; ball_lost = lost; all_points_hit = aph;
    repeat (n) @(posedge clk_50m);
    #2;
  endtask

  task automatic doPress();
    applyStimulus(1, 0, 0, 10);
    applyStimulus(0, 0, 0, 10);
  endtask

  task automatic pulse(input bit lost, input bit aph);
    applyStimulus(0, lost, aph, 1);
    applyStimulus(0, 0, 0, 1);
  endtask

  task automatic waitState(input string name, input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      @(posedge clk_50m); #2; n++;
    end
    checkOutput(name, int'(state), target);
  endtask

  task automatic measurePeriod(input string name, input int exp);
    int t1, t2, n;
    bit seen;
    seen = 0; n = 0;
    while (!seen && n < 100) begin @(negedge clk_50m); seen = move_en; n++; end
    t1 = cyc; seen = 0; n = 0;
    while (!seen && n < 100) begin @(negedge clk_50m); seen = move_en; n++; end
    t2 = cyc;
    checkOutput(name, t2 - t1, exp);
    @(posedge clk_50m); #2;
  endtask

  initial begin
    int ng0, rr0, me0, bh0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk_50m);
    #2;
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_lives", int'(lives), 3);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_model_state", m_state, 0);
    checkOutput("rst_model_lives", m_lives, 3);
    rst_n = 1'b1;

    // 1: start a game
    doPress();
    checkOutput("t1_serve", int'(state), S_SERVE);
    checkOutput("t1_new_game_cnt", ng_count, 1);
    checkOutput("t1_round_rst_cnt", rr_count, 1);
    waitState("t1_play", S_PLAY, 100);
    measurePeriod("t1_period_l0", 10);

    // 2: level up and saturate
    repeat (5) pulse(0, 1);
    checkOutput("t2_level5", int'(level), 5);
    checkOutput("t2_model_level5", m_level, 5);
    measurePeriod("t2_period_l5", 4);
    repeat (11) pulse(0, 1);
    checkOutput("t2_level15", int'(level), 15);
    measurePeriod("t2_period_l15", 4);

    // 3: pause and resume
    doPress();
    checkOutput("t3_pause", int'(state), S_PAUSE);
    me0 = me_count; bh0 = blink_hi;
    applyStimulus(0, 0, 0, 20);
    checkOutput("t3_no_move_in_pause", me_count - me0, 0);
    checkOutput("t3_blink_active", int'(blink_hi - bh0 > 0), 1);
    doPress();
    checkOutput("t3_resume", int'(state), S_PLAY);

    // 4: simultaneous loss and level-up
    pulse(1, 1);
    checkOutput("t4_lost", int'(state), S_LOST);
    checkOutput("t4_lives", int'(lives), 2);
    checkOutput("t4_level_kept", int'(level), 15);
    rr0 = rr_count;
    waitState("t4_serve", S_SERVE, 100);
    applyStimulus(0, 0, 0, 2);
    checkOutput("t4_round_rst", rr_count - rr0, 1);

    // 5: lose remaining lives, game over, restart
    for (int i = 0; i < 2; i++) begin
      waitState("t5_play", S_PLAY, 200);
      pulse(1, 0);
    end
    waitState("t5_over", S_OVER, 200);
    checkOutput("t5_lives0", int'(lives), 0);
    doPress();
    checkOutput("t5_idle", int'(state), S_IDLE);
    ng0 = ng_count;
    doPress();
    checkOutput("t5_restart_state", int'(state), S_SERVE);
    checkOutput("t5_restart_lives", int'(lives), 3);
    checkOutput("t5_restart_level", int'(level), 0);
    checkOutput("t5_new_game", ng_count - ng0, 1);

    // 6: glitches ignored, then asynchronous reset mid-play
    waitState("t6_play", S_PLAY, 200);
    repeat (3) begin
      applyStimulus(1, 0, 0, 2);
      applyStimulus(0, 0, 0, 8);
    end
    checkOutput("t6_glitch_no_change", int'(state), S_PLAY);
    repeat (2) pulse(0, 1);
    checkOutput("t6_level2", int'(level), 2);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_state", int'(state), 0);
    checkOutput("t6_rst_level", int'(level), 0);
    checkOutput("t6_rst_move_en", int'(move_en), 0);
    checkOutput("t6_rst_blink", int'(blink), 0);
    applyStimulus(0, 0, 0, 3);
    rst_n = 1'b1;
    ng0 = ng_count; rr0 = rr_count;
    applyStimulus(0, 0, 0, 10);
    checkOutput("t6_no_pulse_ng", ng_count - ng0, 0);
    checkOutput("t6_no_pulse_rr", rr_count - rr0, 0);
    checkOutput("t6_idle_after", int'(state), S_IDLE);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_seq.md
# game_seq

Game sequencer for the VGA paddle/ball game. It owns the game state machine (idle, serve, play, pause, lost, over), the lives and level counters, and the debounced start/pause button. It generates the position-update strobe `move_en`, whose period shortens as the level rises. It sits between the board I/O and the game datapath, and it is the only source of `move_en`, `round_rst` and `new_game` for that datapath.

## Interface
- TICK_BASE, 500000: `move_en` period in cycles at level 0 (100 Hz).
- TICK_STEP, 50000: period reduction per level.
- TICK_MIN, 200000: period floor.
- SERVE_TICKS, 100: ticks spent in SERVE and in LOST (1 s at level 0).
- LIVES_INIT, 3: lives at game start (1..3).
- DEBOUNCE_CYC, 1000000: cycles the `start_btn` level must be stable (20 ms).
- clk_50m  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- start_btn  in  1  raw start/pause push-button, asynchronous, active-high.
- ball_lost  in  1  1-cycle pulse from datapath: ball reached the floor.
- all_points_hit  in  1  1-cycle pulse from datapath: all score points cleared.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, OVER=5.
- move_en  out  1  1-cycle position-update strobe, PLAY only.
- round_rst  out  1  1-cycle pulse: recentre ball and board.
- new_game  out  1  1-cycle pulse: clear score, respawn points.
- lives  out  2  remaining lives.
- level  out  4  current level, 0..15.
- blink  out  1  HUD blink, 1 Hz square wave in PAUSE/OVER, else 0.

## Operation
- **Button path**
  - 2-FF synchronizer on `start_btn`.
  - Debounce counter: resets on any change of the synced level. The debounced level updates after DEBOUNCE_CYC stable cycles.
  - `press` = 1-cycle internal pulse on the debounced rising edge.
- **Tick generator**
  - `period = max(TICK_BASE - level*TICK_STEP, TICK_MIN)`, computed in 21-bit signed arithmetic so underflow clamps to TICK_MIN.
  - 20-bit counter; `tick` fires when `cnt >= period-1`, and cnt then returns to 0. The `>=` handles a period shrinking mid-count.
  - The counter free-runs in every state except PAUSE, where it holds its value.
  - `move_en = tick && state==PLAY`.
- **Tick timer**: counts ticks in SERVE and LOST. It clears on every state entry.
- **FSM transitions**
  - IDLE: `press` → SERVE. On that transition: `lives`=LIVES_INIT, `level`=0, pulse `new_game` and `round_rst`.
  - SERVE: after SERVE_TICKS ticks → PLAY. `press` is ignored.
  - PLAY, priority high to low:
    - `ball_lost` → LOST; `lives` decrements on this transition.
    - `press` → PAUSE.
    - `all_points_hit` → `level`+1, saturating at 15; state stays PLAY.
  - PAUSE: `press` → PLAY. `ball_lost` and `all_points_hit` are ignored.
  - LOST: after SERVE_TICKS ticks:
    - if `lives==0` → OVER;
    - else → SERVE with a `round_rst` pulse.
  - OVER: `press` → IDLE.
- **blink**: toggles every 25,000,000 cycles from an independent counter. The counter clears on entry to PAUSE/OVER; output is 0 in other states.
- `lives` never wraps below 0; a decrement is only possible from lives ≥ 1, because reaching 0 forces OVER.

## Timing
- **Reset values**: state=IDLE, lives=LIVES_INIT, level=0. `move_en`, `round_rst`, `new_game` and `blink` are 0. All counters are 0.
- **Output registration**
  - All outputs are registered.
  - `state` changes on the clock edge after the triggering pulse.
  - `round_rst`/`new_game` are high for exactly the first cycle the new state is visible.
- **Latency**
  - Button to `press`: 2 (sync) + DEBOUNCE_CYC + 1 cycles.
  - `move_en` is high for 1 cycle every `period` cycles. The first `move_en` after PLAY entry follows the next natural tick; the counter is not restarted.
- **Level change**: the new `period` applies from the cycle after `level` updates. If `cnt` already ≥ `period-1`, the tick fires immediately.
- **Simultaneous events**
  - `ball_lost` with `press` or `all_points_hit` in PLAY: LOST only, level unchanged.
  - `press` in the same cycle as a SERVE/LOST timer expiry: ignored.
- **Reset mid-operation**: all state returns to reset values asynchronously. No output pulse is generated on deassertion.

## Test plan
Bench parameters: TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, SERVE_TICKS=3, DEBOUNCE_CYC=4, LIVES_INIT=3.

1. Reset, then hold `start_btn` 10 cycles → `press` occurs; `new_game`=`round_rst`=1 for one cycle; state=1. After 3 ticks, state=2 and `move_en` pulses every 10 cycles.
2. In PLAY, pulse `all_points_hit` 5 times → `level`=5, `move_en` period 4. Pulse 11 more → `level` saturates at 15, period stays 4.
3. In PLAY, apply a `start_btn` press → state=3, `move_en`=0, `blink` toggling, tick count frozen. Press again → state=2; the first `move_en` arrives at the remaining count, not a full period.
4. Pulse `ball_lost` and `all_points_hit` in the same cycle → state=4, lives=2, level unchanged. After 3 ticks: state=1 with a `round_rst` pulse.
5. Lose 3 lives → after the third LOST, state=5. A press → state=0; the next press restores lives=3 and level=0.
6. Apply 2-cycle glitches on `start_btn` → no state change. Assert `rst_n` low mid-PLAY → all outputs at reset values immediately.
